// File: rtl/sipo_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sipo_deframer                                                    |
// | Brief   : Framed serial-to-parallel deframer with even-parity/stop checks, |
// |           one-entry valid/ready output buffer and overrun detection.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sipo_deframer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_dout;
  logic             r_par;
  logic             r_valid;
  logic             r_perr;
  logic             r_ferr;
  logic             r_ovr;

  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_xfer;
  logic             w_load_ok;

  // Data arrives LSB first, so each new bit enters at the top and drifts down.
  always_comb begin
    w_shift_nxt            = r_shift >> 1;
    w_shift_nxt[WIDTH-1]   = sin;
  end

  assign w_xfer    = r_valid & dout_ready;
  assign w_load_ok = ~r_valid | w_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (sin_en) begin
        case (r_state)
          S_IDLE: begin
            if (!sin) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
            end
          end
          S_DATA: begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_par   <= sin;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!sin) begin
              r_ferr <= 1'b1;
            end else if (w_load_ok) begin
              // A load in the same cycle as a transfer overrides the clear above.
              r_dout  <= r_shift;
              r_perr  <= (^r_shift) ^ r_par;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sipo_deframer                                                 |
// | Brief   : Scoreboard bench: frame-level reference model plus monitor.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sipo_deframer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sin;
  logic             sin_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  sipo_deframer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Driver annotations describing the frame whose stop bit is on the line.
  logic             drv_frame_end = 1'b0;
  logic [WIDTH-1:0] drv_word      = '0;
  logic             drv_perr      = 1'b0;
  logic             drv_stop_ok   = 1'b1;
  logic             rdy_cmd       = 1'b0;
  bit               rand_mode     = 1'b0;
  bit               mon_on        = 1'b0;

  // Reference model state: buffer occupancy and expected pulses.
  logic             m_valid = 1'b0;
  logic             exp_fe  = 1'b0;
  logic             exp_ov  = 1'b0;
  logic [WIDTH:0]   sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: buffer rules applied at each clock edge.
  always @(posedge clk) begin
    logic xfer;
    xfer   = m_valid && dout_ready;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      sb.delete();
    end else if (drv_frame_end) begin
      if (!drv_stop_ok) begin
        exp_fe = 1'b1;
        if (xfer) m_valid = 1'b0;
      end else if (!m_valid || xfer) begin
        m_valid = 1'b1;
        sb.push_back({drv_perr, drv_word});
      end else begin
        exp_ov = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  end

  // Monitor: per-cycle flag checks, word check on every handshake.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_valid});
      chk("frame_err",  {31'd0, frame_err},  {31'd0, exp_fe});
      chk("overrun",    {31'd0, overrun},    {31'd0, exp_ov});
      if (m_valid && dout_ready) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          logic [WIDTH:0] e;
          e = sb.pop_front();
          chk("dout",       {{(32-WIDTH){1'b0}}, dout}, {{(32-WIDTH){1'b0}}, e[WIDTH-1:0]});
          chk("parity_err", {31'd0, parity_err},        {31'd0, e[WIDTH]});
        end
      end
    end
  end

  task automatic tick(input bit en, input bit s, input bit fe);
    @(posedge clk);
    #1;
    sin_en        = en;
    sin           = s;
    drv_frame_end = fe;
    dout_ready    = rand_mode ? 1'($urandom_range(0, 1)) : rdy_cmd;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic strobe(input int gap, input bit s, input bit fe);
    repeat (gap) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, s, fe);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] data, input bit bad_par,
                            input bit bad_stop, input int gap, input bit rdy_stop);
    strobe(gap, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) strobe(gap, data[i], 1'b0);
    strobe(gap, (^data) ^ bad_par, 1'b0);
    drv_word    = data;
    drv_perr    = bad_par;
    drv_stop_ok = !bad_stop;
    if (rdy_stop) rdy_cmd = 1'b1;
    strobe(gap, !bad_stop, 1'b1);
    rdy_cmd = 1'b0;
  endtask

  task automatic drain();
    rdy_cmd = 1'b1;
    idle(2);
    rdy_cmd = 1'b0;
    idle(1);
  endtask

  initial begin
    rst        = 1'b1;
    sin        = 1'b1;
    sin_en     = 1'b0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_dout",  {28'd0, dout},  32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_perr",  {31'd0, parity_err}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_err},  32'd0);
    chk("rst_ovr",   {31'd0, overrun},    32'd0);

    // Good word held until consumer is ready.
    send_frame(4'hA, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    drain();
    // Wrong parity bit.
    send_frame(4'h7, 1'b1, 1'b0, 0, 1'b0);
    drain();
    // Bad stop bit, then a good frame.
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0);
    idle(2);
    send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0);
    drain();
    // Overrun, then a load coinciding with a transfer.
    send_frame(4'h1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'h2, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b0, 0, 1'b1);
    idle(2);
    drain();
    // Sparse strobes.
    send_frame(4'h9, 1'b0, 1'b0, 2, 1'b0);
    drain();
    // Reset in the middle of a frame.
    strobe(0, 1'b0, 1'b0);
    strobe(0, 1'b1, 1'b0);
    strobe(0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    sin_en = 1'b0;
    drv_frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_dout",  {28'd0, dout},  32'd0);
    chk("mrst_valid", {31'd0, dout_valid}, 32'd0);
    chk("mrst_perr",  {31'd0, parity_err}, 32'd0);
    send_frame(4'h6, 1'b0, 1'b0, 0, 1'b0);
    drain();

    // Randomized frames with random consumer back-pressure.
    rand_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_frame(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 2)), 1'b0);
      idle(int'($urandom_range(0, 1)));
    end
    rand_mode = 1'b0;
    drain();
    idle(2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
